conv_mesh_grid: RTL and testbench
=================================

CONV_MESH_GRID -- requirements
Module: conv_mesh_grid

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; the clock port is ck and the reset port is res.
REQ-002 Parameter MESH_W, default 20, mesh columns (>=2).
REQ-003 Parameter MESH_H, default 20, mesh rows (>=2).
REQ-004 Parameter DW, default 12, unsigned pixel width.
REQ-005 Parameter CW, default 8, signed coefficient width; derived localparam ACC_W = DW+CW+4.
REQ-006 ck  in  1  clock, all logic on rising edge.
REQ-007 res  in  1  synchronous active-high reset.
REQ-008 start  in  1  begin job; sampled only in IDLE.
REQ-009 coef  in  5*CW  packed signed stencil: [CW-1:0]=C, then N, S, E, W in ascending slices; latched on accepted start.
REQ-010 pad_mode  in  2  edge policy: 0 zero, 1 replicate, 2 wrap; 3 treated as 0; latched on accepted start.
REQ-011 pix_valid / pix_data  in  1 / DW  input pixel stream, raster order, x fastest.
REQ-012 pix_ready  out  1  high only in LOAD.
REQ-013 out_valid / out_data  out  1 / ACC_W  signed result stream, raster order.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse when the last result is accepted.

Function
REQ-017 FSM SHALL have states IDLE, LOAD, CALC, DRAIN.
REQ-018 IDLE -> LOAD on start=1; start in any other state SHALL be ignored.
REQ-019 In LOAD a pixel SHALL be written at cell (x,y) on each pix_valid&&pix_ready cycle; x wraps at MESH_W-1 and y increments.
REQ-020 The accept of pixel (MESH_W-1, MESH_H-1) SHALL move LOAD -> CALC; pix_ready SHALL be 0 in the following cycle.
REQ-021 CALC SHALL last exactly one cycle; every cell computes R = C*P + N*Pn + S*Ps + E*Pe + W*Pw in full ACC_W signed precision, with pixels zero-extended. All results SHALL be registered simultaneously.
REQ-022 Neighbours: north is y-1, south is y+1, west is x-1, east is x+1.
REQ-023 Off-mesh neighbours SHALL follow the latched pad_mode. Zero: 0. Replicate: the cell's own edge-clamped coordinate. Wrap: the index modulo MESH_W or MESH_H.
REQ-024 CALC -> DRAIN unconditionally, so the first out_valid is asserted 2 cycles after the last pixel accept.
REQ-025 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal R of the current raster index; the index SHALL advance only on out_valid&&out_ready.
REQ-026 While out_ready=0, out_data and out_valid SHALL hold stable.
REQ-027 The accept of the last result SHALL pulse done for one cycle and return the FSM to IDLE; out_valid SHALL be 0 in the next cycle.
REQ-028 A new start SHALL be accepted in the cycle after done; coefficients and pad_mode SHALL stay constant for the whole job, regardless of input changes.
REQ-029 pix_valid outside LOAD and out_ready outside DRAIN SHALL have no effect.

Reset
REQ-030 res=1 SHALL force IDLE, clear the raster counters, pixel grid, result grid, latched coef and pad_mode to 0, and drive pix_ready, out_valid, out_data, busy and done to 0 in the next cycle.
REQ-031 Reset SHALL have priority over all other inputs and SHALL abort any job mid-LOAD, mid-CALC or mid-DRAIN with no partial output afterwards.

Verification (MESH_W=4, MESH_H=3, DW=8, CW=8)
REQ-032 Identity: C=1, others 0, pad 0, pixels = raster index 0..11 -> out_data sequence 0..11, then done pulse.
REQ-033 Zero pad: all pixels 10, all coef 1 -> corners 30, edges 40, interior (1,1),(2,1) 50.
REQ-034 Replicate pad: same stimulus as REQ-033 -> all 12 results 50.
REQ-035 Wrap pad: pixels = raster index, N=1, others 0 -> out(2,0)=10, out(0,1)=0, out(3,2)=7.
REQ-036 Sign and backpressure: C=-128, all pixels 255 -> every result -32640. With out_ready held 0 for 5 cycles mid-DRAIN, the held word is unchanged and all 12 results are received exactly once.
REQ-037 Reset mid-LOAD after 5 pixels -> next cycle busy=0 and pix_ready=0. A fresh full job afterwards matches REQ-032.

Source files
------------

// File: rtl/conv_mesh_grid_if.sv
// Handshake bundle for conv_mesh_grid: job control, pixel input stream, result output stream.
// master = job/stream source and sink, slave = the convolution engine.
interface conv_mesh_grid_if #(
    parameter int unsigned DW = 12,
    parameter int unsigned CW = 8
);
    localparam int unsigned ACC_W = DW + CW + 4;

    logic                    start;
    logic [5*CW-1:0]         coef;
    logic [1:0]              pad_mode;
    logic                    pix_valid;
    logic [DW-1:0]           pix_data;
    logic                    pix_ready;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output start, coef, pad_mode, pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, coef, pad_mode, pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/conv_mesh_grid.sv
// Loads a MESH_W x MESH_H pixel grid, applies a 5-point signed stencil to every cell in one
// cycle, then streams the results out in raster order.
module conv_mesh_grid #(
    parameter int unsigned MESH_W = 20,
    parameter int unsigned MESH_H = 20,
    parameter int unsigned DW     = 12,
    parameter int unsigned CW     = 8
) (
    input logic             ck,
    input logic             res,
    conv_mesh_grid_if.slave bus
);
    localparam int unsigned ACC_W = DW + CW + 4;
    localparam int unsigned N     = MESH_W * MESH_H;
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned XW    = $clog2(MESH_W);
    localparam int unsigned YW    = $clog2(MESH_H);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDrain} state_e;

    state_e                  state_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           wr_idx;
    logic [5*CW-1:0]         coef_q;
    logic [1:0]              pad_q;
    logic                    done_q;
    logic [DW-1:0]           pix_grid [N];
    logic signed [ACC_W-1:0] res_grid [N];
    logic signed [ACC_W-1:0] calc     [N];
    logic signed [ACC_W-1:0] cf       [5];

    function automatic logic signed [ACC_W-1:0] tap(input logic [DW-1:0] p);
        return ACC_W'(p);
    endfunction

    // Off-mesh neighbours: wrap reads the far side, replicate reads the cell itself.
    function automatic logic [DW-1:0] nbr(input logic at_edge, input logic [1:0] pad,
                                          input logic [DW-1:0] far, input logic [DW-1:0] own);
        if (!at_edge || pad == 2'd2) return far;
        if (pad == 2'd1) return own;
        return '0;
    endfunction

    assign wr_idx = IW'(int'(y_q) * int'(MESH_W) + int'(x_q));

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            cf[k] = ACC_W'($signed(coef_q[k*CW +: CW]));
        end
    end

    for (genvar gy = 0; gy < MESH_H; gy++) begin : g_row
        for (genvar gx = 0; gx < MESH_W; gx++) begin : g_col
            localparam int  I  = gy * MESH_W + gx;
            localparam bit  EN = (gy == 0);
            localparam bit  ES = (gy == MESH_H - 1);
            localparam bit  EW = (gx == 0);
            localparam bit  EE = (gx == MESH_W - 1);
            localparam int  IN = EN ? (MESH_H - 1) * MESH_W + gx : I - MESH_W;
            localparam int  IS = ES ? gx : I + MESH_W;
            localparam int  IE = EE ? I - (MESH_W - 1) : I + 1;
            localparam int  IWS = EW ? I + (MESH_W - 1) : I - 1;
            logic [DW-1:0] pn, ps, pe, pw;

            assign pn = nbr(EN, pad_q, pix_grid[IN], pix_grid[I]);
            assign ps = nbr(ES, pad_q, pix_grid[IS], pix_grid[I]);
            assign pe = nbr(EE, pad_q, pix_grid[IE], pix_grid[I]);
            assign pw = nbr(EW, pad_q, pix_grid[IWS], pix_grid[I]);
            assign calc[I] = cf[0] * tap(pix_grid[I]) + cf[1] * tap(pn) + cf[2] * tap(ps)
                           + cf[3] * tap(pe) + cf[4] * tap(pw);
        end
    end

    always_ff @(posedge ck) begin
        if (res) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            coef_q  <= '0;
            pad_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                pix_grid[i] <= '0;
                res_grid[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        coef_q  <= bus.coef;
                        pad_q   <= bus.pad_mode;
                        x_q     <= '0;
                        y_q     <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.pix_valid) begin
                        pix_grid[wr_idx] <= bus.pix_data;
                        if (x_q == XW'(MESH_W - 1)) begin
                            x_q <= '0;
                            if (y_q == YW'(MESH_H - 1)) begin
                                y_q     <= '0;
                                state_q <= StCalc;
                            end else begin
                                y_q <= y_q + 1'b1;
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                StCalc: begin
                    for (int i = 0; i < N; i++) begin
                        res_grid[i] <= calc[i];
                    end
                    idx_q   <= '0;
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (bus.out_ready) begin
                        if (idx_q == IW'(N - 1)) begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.pix_ready = (state_q == StLoad);
    assign bus.out_valid = (state_q == StDrain);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.out_data  = res_grid[idx_q];
endmodule

// File: tb/tb_conv_mesh_grid.sv
// Directed bench for conv_mesh_grid on a 4x3 mesh: identity, pad modes, sign, backpressure,
// reset abort.
module tb_conv_mesh_grid;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int CW = 8;

    logic ck = 1'b0;
    logic res;
    always #5 ck = ~ck;

    conv_mesh_grid_if #(.DW(DW), .CW(CW)) bus ();

    conv_mesh_grid #(
        .MESH_W(W),
        .MESH_H(H),
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .ck (ck),
        .res(res),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pix_v [N];
    int exp_v [N];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic start_job(input logic [5*CW-1:0] c, input logic [1:0] p);
        bus.coef     = c;
        bus.pad_mode = p;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        // Scramble the live inputs; the job must keep the latched copies.
        bus.coef     = 40'h7F_80_33_C5_9A;
        bus.pad_mode = ~p;
        check("start_busy", bus.busy, 1);
        check("start_pix_ready", bus.pix_ready, 1);
    endtask

    task automatic load_pix(input int count);
        for (int i = 0; i < count; i++) begin
            if (i == 6) begin
                bus.pix_valid = 1'b0;
                bus.pix_data  = 8'hFF;
                step();
            end
            check("load_pix_ready", bus.pix_ready, 1);
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'(pix_v[i]);
            step();
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic drain(input int stall_at);
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (k == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    step();
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, exp_v[k]);
                end
                bus.out_ready = 1'b1;
            end
            check("out_valid", bus.out_valid, 1);
            check($sformatf("out_data[%0d]", k), bus.out_data, exp_v[k]);
            step();
        end
        check("done_pulse", bus.done, 1);
        check("post_out_valid", bus.out_valid, 0);
        check("post_busy", bus.busy, 0);
        bus.out_ready = 1'b0;
        step();
        check("done_clear", bus.done, 0);
        check("idle_out_valid", bus.out_valid, 0);
    endtask

    task automatic run_job(input logic [5*CW-1:0] c, input logic [1:0] p, input int stall_at);
        start_job(c, p);
        load_pix(N);
        check("calc_pix_ready", bus.pix_ready, 0);
        check("calc_out_valid", bus.out_valid, 0);
        step();
        drain(stall_at);
    endtask

    initial begin
        res           = 1'b1;
        bus.start     = 1'b0;
        bus.coef      = '0;
        bus.pad_mode  = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_busy", bus.busy, 0);
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_done", bus.done, 0);
        res = 1'b0;
        step();

        // Identity: C=1.
        for (int i = 0; i < N; i++) begin
            pix_v[i] = i;
            exp_v[i] = i;
        end
        run_job(40'h00_00_00_00_01, 2'd0, -1);

        // Zero pad, all coefficients 1: 10 per in-mesh tap.
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                pix_v[y*W+x] = 10;
                exp_v[y*W+x] = 10 * (1 + int'(y > 0) + int'(y < H - 1)
                                       + int'(x > 0) + int'(x < W - 1));
            end
        end
        run_job(40'h01_01_01_01_01, 2'd0, -1);
        // pad_mode 3 behaves as zero pad.
        run_job(40'h01_01_01_01_01, 2'd3, -1);

        // Replicate pad.
        for (int i = 0; i < N; i++) exp_v[i] = 50;
        run_job(40'h01_01_01_01_01, 2'd1, -1);

        // Wrap pad, N=1: result is the pixel one row up, modulo H.
        for (int i = 0; i < N; i++) begin
            pix_v[i] = i;
            exp_v[i] = (i >= W) ? i - W : i + (H - 1) * W;
        end
        run_job(40'h00_00_00_01_00, 2'd2, -1);
        check("wrap_out_2_0", exp_v[2], 10);

        // Sign: C=-128 on 255, with a 5-cycle stall mid-drain.
        for (int i = 0; i < N; i++) begin
            pix_v[i] = 255;
            exp_v[i] = -32640;
        end
        run_job(40'h00_00_00_00_80, 2'd0, 5);

        // Reset mid-load after 5 pixels, then a fresh identity job.
        for (int i = 0; i < N; i++) begin
            pix_v[i] = i;
            exp_v[i] = i;
        end
        start_job(40'h00_00_00_00_01, 2'd0);
        load_pix(5);
        res = 1'b1;
        step();
        check("abort_busy", bus.busy, 0);
        check("abort_pix_ready", bus.pix_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        res = 1'b0;
        bus.pix_valid = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            step();
            check("abort_idle_valid", bus.out_valid, 0);
            check("abort_idle_busy", bus.busy, 0);
        end
        bus.pix_valid = 1'b0;
        bus.out_ready = 1'b0;
        run_job(40'h00_00_00_00_01, 2'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
